a2d_chnl_sched: RTL

A2D_CHNL_SCHED -- requirements
Module: a2d_chnl_sched

---
 rtl/a2d_chnl_sched_if.sv | 21 ++
 rtl/a2d_chnl_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/a2d_chnl_sched_if.sv
// SPI handshake between the A2D channel scheduler (master) and the SPI shift engine (slave).
interface a2d_chnl_sched_if;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_resp;

  modport master (
    output spi_wrt,
    output spi_cmd,
    input  spi_done,
    input  spi_resp
  );

  modport slave (
    input  spi_wrt,
    input  spi_cmd,
    output spi_done,
    output spi_resp
  );
endinterface

// File: rtl/a2d_chnl_sched.sv
// Round-robin A2D scheduler: paced rounds of command/read SPI pairs over batt, curr, brake, torque.
// Optional macro A2D_FILT_EN enables a 3:1 IIR on each result register.
module a2d_chnl_sched #(
  parameter int unsigned PACE_CYC = 16384,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  a2d_chnl_sched_if.master        spi,
  output logic [11:0]             batt,
  output logic [11:0]             curr,
  output logic [11:0]             brake,
  output logic [11:0]             torque,
  output logic                    cnv_cmplt
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DAT_W = 12;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned NCHNL = 4;

  localparam logic [CNT_W-1:0] PACE_LAST = CNT_W'(PACE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NCHNL - 1);

  localparam logic [2:0] PACE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] CMD_WT  = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] READ    = 3'd4;
  localparam logic [2:0] READ_WT = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_nxt_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_nxt_idx;
  logic             w_rd_done;
  logic             w_wrt;
  logic [2:0]       w_ch;
  logic             r_spi_wrt;
  logic [15:0]      r_spi_cmd;
  logic             r_cnv;
  logic [DAT_W-1:0] r_res [NCHNL];
  logic [DAT_W-1:0] w_sample;
  logic [DAT_W-1:0] w_upd;

  // Next-state, channel index and completion decode
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_rd_done   = 1'b0;
    case (r_state)
      PACE: begin
        if (r_cnt == PACE_LAST) begin
          w_nxt_state = CMD;
          w_nxt_idx   = '0;
        end
      end
      CMD:     w_nxt_state = CMD_WT;
      CMD_WT:  if (spi.spi_done) w_nxt_state = GAP;
      GAP:     if (r_cnt == GAP_LAST) w_nxt_state = READ;
      READ:    w_nxt_state = READ_WT;
      READ_WT: begin
        if (spi.spi_done) begin
          w_rd_done = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_nxt_state = PACE;
          end else begin
            w_nxt_state = CMD;
            w_nxt_idx   = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_nxt_state = PACE;
    endcase
  end

  // Counter only runs in the timed states and restarts on every state entry
  always_comb begin
    w_nxt_cnt = '0;
    if ((w_nxt_state == r_state) && ((r_state == PACE) || (r_state == GAP)))
      w_nxt_cnt = r_cnt + CNT_W'(1);
  end

  // Physical mux channel for the scheduled index (ch2 is skipped)
  always_comb begin
    w_ch = 3'd0;
    case (w_nxt_idx)
      2'd0:    w_ch = 3'd0;
      2'd1:    w_ch = 3'd1;
      2'd2:    w_ch = 3'd3;
      default: w_ch = 3'd4;
    endcase
  end

  assign w_wrt    = (w_nxt_state == CMD) || (w_nxt_state == READ);
  assign w_sample = spi.spi_resp[DAT_W-1:0];

`ifdef A2D_FILT_EN
  logic [NCHNL-1:0] r_seen;
  logic [13:0]      w_sum;

  assign w_sum = (14'(r_res[r_idx]) * 14'd3) + 14'(w_sample);
  assign w_upd = r_seen[r_idx] ? w_sum[13:2] : w_sample;

  // First result after reset seeds the filter with the raw sample
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_seen <= '0;
    else if (w_rd_done)
      r_seen[r_idx] <= 1'b1;
  end
`else
  assign w_upd = w_sample;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= PACE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_spi_wrt <= 1'b0;
      r_spi_cmd <= '0;
      r_cnv     <= 1'b0;
      for (int i = 0; i < int'(NCHNL); i++) r_res[i] <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_idx     <= w_nxt_idx;
      r_spi_wrt <= w_wrt;
      r_cnv     <= w_rd_done && (r_idx == IDX_LAST);
      if (w_wrt)
        r_spi_cmd <= {2'b00, w_ch, 11'h000};
      if (w_rd_done)
        r_res[r_idx] <= w_upd;
    end
  end

  assign spi.spi_wrt = r_spi_wrt;
  assign spi.spi_cmd = r_spi_cmd;
  assign cnv_cmplt   = r_cnv;
  assign batt        = r_res[0];
  assign curr        = r_res[1];
  assign brake       = r_res[2];
  assign torque      = r_res[3];

endmodule
